// File: rtl/board_port_arbiter_if.sv
// Request/grant/result bundle for the Connect Four board memory port arbiter.
// "master" is the requester/memory side, "slave" is the arbiter itself.
interface board_port_arbiter_if;
    logic       vga_req;
    logic [2:0] vga_row;
    logic [2:0] vga_col;
    logic       vga_gnt;
    logic       vga_valid;
    logic [1:0] vga_data;
    logic       vga_miss;

    logic       wr_req;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    logic [1:0] wr_data;
    logic       wr_gnt;

    logic       win_req;
    logic [2:0] win_row;
    logic [2:0] win_col;
    logic       win_gnt;
    logic       win_valid;
    logic [1:0] win_data;

    logic       dbg_req;
    logic [2:0] dbg_row;
    logic [2:0] dbg_col;
    logic       dbg_gnt;
    logic       dbg_valid;
    logic [1:0] dbg_data;

    logic       mem_en;
    logic       mem_we;
    logic [2:0] mem_row;
    logic [2:0] mem_col;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata;

    modport master (
        output vga_req, vga_row, vga_col,
        output wr_req, wr_row, wr_col, wr_data,
        output win_req, win_row, win_col,
        output dbg_req, dbg_row, dbg_col,
        output mem_rdata,
        input  vga_gnt, vga_valid, vga_data, vga_miss,
        input  wr_gnt,
        input  win_gnt, win_valid, win_data,
        input  dbg_gnt, dbg_valid, dbg_data,
        input  mem_en, mem_we, mem_row, mem_col, mem_wdata
    );

    modport slave (
        input  vga_req, vga_row, vga_col,
        input  wr_req, wr_row, wr_col, wr_data,
        input  win_req, win_row, win_col,
        input  dbg_req, dbg_row, dbg_col,
        input  mem_rdata,
        output vga_gnt, vga_valid, vga_data, vga_miss,
        output wr_gnt,
        output win_gnt, win_valid, win_data,
        output dbg_gnt, dbg_valid, dbg_data,
        output mem_en, mem_we, mem_row, mem_col, mem_wdata
    );
endinterface

// File: rtl/board_port_arbiter.sv
// Single-port board memory arbiter: VGA > write > round-robin(win, dbg).
// Define ARB_STARVE_GUARD_EN to add wait counters that let starved requesters pre-empt VGA.
module board_port_arbiter #(
    parameter int unsigned ROWS     = 6,
    parameter int unsigned COLS     = 7,
    parameter int unsigned MAX_WAIT = 8
) (
    input logic                 clk,
    input logic                 rst,
    board_port_arbiter_if.slave bus
);

    typedef enum logic [2:0] {GNT_NONE, GNT_VGA, GNT_WR, GNT_WIN, GNT_DBG} grant_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_WIN, OWN_DBG} owner_t;

    grant_t sel;
    owner_t owner_q;
    logic   oor_q;
    logic   rr_q;
    logic   vga_oor, wr_oor, win_oor, dbg_oor;
    logic   wr_starved, win_starved, dbg_starved;

    function automatic logic out_of_range(input logic [2:0] row, input logic [2:0] col);
        return (32'(row) >= ROWS) || (32'(col) >= COLS);
    endfunction

    assign vga_oor = out_of_range(bus.vga_row, bus.vga_col);
    assign wr_oor  = out_of_range(bus.wr_row, bus.wr_col);
    assign win_oor = out_of_range(bus.win_row, bus.win_col);
    assign dbg_oor = out_of_range(bus.dbg_row, bus.dbg_col);

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wr_wait_q, win_wait_q, dbg_wait_q;

    function automatic logic [CW-1:0] wait_next(input logic req, input logic gnt,
                                                input logic [CW-1:0] cnt);
        if (!req || gnt)
            return '0;
        else if (cnt == CW'(MAX_WAIT))
            return cnt;
        else
            return cnt + 1'b1;
    endfunction

    assign wr_starved  = bus.wr_req  && (wr_wait_q  == CW'(MAX_WAIT));
    assign win_starved = bus.win_req && (win_wait_q == CW'(MAX_WAIT));
    assign dbg_starved = bus.dbg_req && (dbg_wait_q == CW'(MAX_WAIT));
    assign bus.vga_miss = !rst && bus.vga_req && !bus.vga_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_wait_q  <= '0;
            win_wait_q <= '0;
            dbg_wait_q <= '0;
        end else begin
            wr_wait_q  <= wait_next(bus.wr_req,  bus.wr_gnt,  wr_wait_q);
            win_wait_q <= wait_next(bus.win_req, bus.win_gnt, win_wait_q);
            dbg_wait_q <= wait_next(bus.dbg_req, bus.dbg_gnt, dbg_wait_q);
        end
    end
`else
    assign wr_starved   = 1'b0;
    assign win_starved  = 1'b0;
    assign dbg_starved  = 1'b0;
    assign bus.vga_miss = 1'b0;
`endif

    // Starved requesters outrank everything; otherwise fixed priority with win/dbg sharing by rr.
    always_comb begin
        sel = GNT_NONE;
        if (!rst) begin
            if (wr_starved)                          sel = GNT_WR;
            else if (win_starved)                    sel = GNT_WIN;
            else if (dbg_starved)                    sel = GNT_DBG;
            else if (bus.vga_req)                    sel = GNT_VGA;
            else if (bus.wr_req)                     sel = GNT_WR;
            else if (bus.win_req && (!bus.dbg_req || !rr_q)) sel = GNT_WIN;
            else if (bus.dbg_req)                    sel = GNT_DBG;
        end
    end

    assign bus.vga_gnt = (sel == GNT_VGA);
    assign bus.wr_gnt  = (sel == GNT_WR);
    assign bus.win_gnt = (sel == GNT_WIN);
    assign bus.dbg_gnt = (sel == GNT_DBG);

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_row   = '0;
        bus.mem_col   = '0;
        bus.mem_wdata = '0;
        unique case (sel)
            GNT_VGA: if (!vga_oor) begin
                bus.mem_en  = 1'b1;
                bus.mem_row = bus.vga_row;
                bus.mem_col = bus.vga_col;
            end
            GNT_WR: if (!wr_oor) begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_row   = bus.wr_row;
                bus.mem_col   = bus.wr_col;
                bus.mem_wdata = bus.wr_data;
            end
            GNT_WIN: if (!win_oor) begin
                bus.mem_en  = 1'b1;
                bus.mem_row = bus.win_row;
                bus.mem_col = bus.win_col;
            end
            GNT_DBG: if (!dbg_oor) begin
                bus.mem_en  = 1'b1;
                bus.mem_row = bus.dbg_row;
                bus.mem_col = bus.dbg_col;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            oor_q   <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            owner_q <= OWN_NONE;
            oor_q   <= 1'b0;
            unique case (sel)
                GNT_VGA: begin owner_q <= OWN_VGA; oor_q <= vga_oor; end
                GNT_WIN: begin owner_q <= OWN_WIN; oor_q <= win_oor; rr_q <= 1'b1; end
                GNT_DBG: begin owner_q <= OWN_DBG; oor_q <= dbg_oor; rr_q <= 1'b0; end
                default: ;
            endcase
        end
    end

    // Out-of-range reads complete on time but never expose the memory bus value.
    assign bus.vga_valid = (owner_q == OWN_VGA);
    assign bus.win_valid = (owner_q == OWN_WIN);
    assign bus.dbg_valid = (owner_q == OWN_DBG);
    assign bus.vga_data  = (bus.vga_valid && !oor_q) ? bus.mem_rdata : '0;
    assign bus.win_data  = (bus.win_valid && !oor_q) ? bus.mem_rdata : '0;
    assign bus.dbg_data  = (bus.dbg_valid && !oor_q) ? bus.mem_rdata : '0;

endmodule

// File: doc/board_port_arbiter.md
# board_port_arbiter

Single-port arbiter for the Connect Four board memory (6 rows × 7 columns, 2-bit cells). It shares the one memory port between the VGA renderer, the game FSM's piece writes, the win checker and the debug board reader. It sits between those requesters and the board storage inside the game top.

## Interface

Parameters:
- ROWS, 6, number of board rows.
- COLS, 7, number of board columns.
- MAX_WAIT, 8, starvation threshold in cycles; used only with the starvation guard.

Ports:
- clk  in  1  system clock (25 MHz pixel clock)
- rst  in  1  synchronous, active-high reset
- vga_req, vga_row[2:0], vga_col[2:0]  in  1/3/3  renderer read request and cell address
- vga_gnt  out  1  renderer read granted this cycle
- vga_valid, vga_data[1:0]  out  1/2  renderer read result
- vga_miss  out  1  one-cycle pulse when a vga_req is denied
- wr_req, wr_row[2:0], wr_col[2:0], wr_data[1:0]  in  1/3/3/2  game FSM write request
- wr_gnt  out  1  write performed this cycle
- win_req, win_row[2:0], win_col[2:0]  in  win-checker read request
- win_gnt, win_valid, win_data[1:0]  out  win-checker grant and result
- dbg_req, dbg_row[2:0], dbg_col[2:0]  in  debug reader request
- dbg_gnt, dbg_valid, dbg_data[1:0]  out  debug grant and result
- mem_en, mem_we  out  1  memory access strobe; write select
- mem_row[2:0], mem_col[2:0], mem_wdata[1:0]  out  memory address and write data
- mem_rdata[1:0]  in  2  memory read data, valid one cycle after mem_en && !mem_we

## Operation

- One memory access per cycle at most. Each requester holds req and its address stable until it sees gnt. The address is consumed in the grant cycle.
- Base priority: VGA > write > round-robin(win, dbg).
- Round-robin pointer rr (0 = win first, 1 = dbg first). After every win or dbg grant, rr moves to the other requester. If only one of the two requests, it is granted regardless of rr.
- A grant drives mem_en=1, mem_we=1 for a write and 0 for a read, plus mem_row/mem_col (and mem_wdata for a write) combinationally in the same cycle.
- Read results:
  - The registered owner tag selects which *_valid pulses high for exactly one cycle, the cycle after the grant.
  - *_data = mem_rdata during that cycle and 2'b00 otherwise.
- Out-of-range address (row ≥ ROWS or col ≥ COLS):
  - Granted normally, but mem_en stays 0.
  - A read returns valid with data 2'b00.
  - A write is acknowledged (wr_gnt) and dropped.
- vga_miss pulses in any cycle with vga_req=1 and vga_gnt=0. This can only happen with the starvation guard compiled in.
- No requests: mem_en=0, all gnt=0, rr unchanged.

## Timing

- Grant: combinational from req and the current state, same cycle.
- Read latency: gnt in cycle N, valid/data in cycle N+1. Back-to-back grants give one result per cycle.
- Write latency: the memory updates at the end of the grant cycle. A read granted in cycle N+1 to the same cell returns the new value.
- Reset values: all gnt, valid, vga_miss, mem_en and mem_we are 0; all *_data and mem_* buses are 0; rr=0; wait counters are 0.
- Reset mid-operation: with rst high in cycle N, no grant occurs in N, and valid is 0 in N+1 even if a grant occurred in N−1.

## Configuration

- ARB_STARVE_GUARD_EN defined:
  - Write, win and dbg each have a saturating wait counter. It increments each cycle the requester's req=1 and gnt=0, and clears on grant or when req drops.
  - Any requester whose counter equals MAX_WAIT pre-empts VGA for one cycle. Among several starved requesters the order is write > win > dbg.
  - vga_gnt=0 and vga_miss=1 in that cycle.
- Not defined: no counters, VGA always wins, and vga_miss is tied to 0.

## Test plan

- Reset: hold rst 3 cycles with all reqs high → every gnt/valid/mem_en is 0. First cycle after release: vga_gnt=1, mem_en=1.
- Priority and round-robin: vga_req=0 and wr_req=0, with win_req and dbg_req held high for 4 cycles → grants win, dbg, win, dbg. valid appears one cycle after each grant, with data matching the preloaded cells.
- Write then read: write 2'b10 to (3,4) in cycle N, win reads (3,4) in cycle N+1 → win_valid in N+2 with win_data=2'b10.
- Out of range: dbg reads (6,2) → mem_en=0, dbg_valid=1 next cycle, dbg_data=2'b00. wr_req to (0,7) → wr_gnt=1 with mem_en=0.
- Starvation, macro defined, MAX_WAIT=8: vga_req and dbg_req held high continuously → dbg_gnt after 8 denied cycles, with vga_miss=1 in that same cycle. Then VGA is granted again.
- Starvation, macro undefined: same stimulus for 100 cycles → dbg_gnt never asserts and vga_miss stays 0.
